btn_reg_edit: RTL and testbench
===============================

BTN_REG_EDIT -- requirements
Module: btn_reg_edit

Interface
REQ-001 Parameter DB_CYCLES, default 250000, px_clk cycles an input must be stable before its debounced level changes.
REQ-002 Parameter REPEAT_DELAY, default 30, frames from the first step to the first auto-repeat step.
REQ-003 Parameter REPEAT_RATE, default 6, frames between auto-repeat steps.
REQ-004 Parameter RESET_VALUE, default 8'h00, value loaded into register on reset and on clear.
REQ-005 Parameter WRAP, default 1: 1 selects modulo-256 stepping; 0 selects saturation at 8'h00 and 8'hFF.
REQ-006 px_clk  input  1  pixel clock; the only clock.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 endframe  input  1  end-of-frame level from the VGA stream; may be asynchronous to edits.
REQ-009 btn_inc  input  1  increment button, active-high, asynchronous.
REQ-010 btn_dec  input  1  decrement button, active-high, asynchronous.
REQ-011 btn_clr  input  1  clear button, active-high, asynchronous.
REQ-012 register  output  8  value for the register display stage; changes only at frame boundaries.
REQ-013 changed  output  1  one-cycle pulse in the cycle register takes a new, different value.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer, then a debouncer: the debounced level follows the synchronized level only after DB_CYCLES consecutive equal samples; any mismatch restarts the count.
REQ-015 frame_tick SHALL be the rising edge of endframe (endframe high, previous sample low), one cycle wide.
REQ-016 A step FSM SHALL have states IDLE, HOLD_INC, HOLD_DEC, REP_INC, REP_DEC, plus a frame counter.
REQ-017 IDLE -> HOLD_INC on debounced btn_inc rising while btn_dec is low; add +1 to pending; frame counter = 0. The same applies symmetrically for dec.
REQ-018 In HOLD_x, count frame_ticks; at REPEAT_DELAY go to REP_x, add one step, reset counter.
REQ-019 In REP_x, add one step every REPEAT_RATE frame_ticks.
REQ-020 Any state -> IDLE when the held button releases (debounced); no step on release.
REQ-021 Both debounced inc and dec high simultaneously: FSM -> IDLE, no step, remains IDLE until both release.
REQ-022 pending SHALL be a signed 5-bit delta, saturating at +15/-16; further steps beyond the limit are dropped.
REQ-023 Debounced btn_clr rising SHALL set clr_pend; clr_pend overrides pending.
REQ-024 On the cycle after frame_tick: if clr_pend, register <= RESET_VALUE; else register <= register + pending, applying WRAP rules per unit step (saturation clamps at the bounds, wrap is modulo 256); then pending <= 0 and clr_pend <= 0.
REQ-025 A step arriving in the same cycle as the apply SHALL be retained in the freshly cleared pending, never lost.
REQ-026 changed SHALL be high exactly in the cycle register updates and only if the new value differs from the old one.
REQ-027 register SHALL never change except in the cycle after frame_tick.

Reset
REQ-028 rst_n low SHALL immediately force register=RESET_VALUE, changed=0, pending=0, clr_pend=0, FSM=IDLE, all debounce/frame counters=0, synchronizer and debounced levels=0, endframe sample=0.
REQ-029 A button held through reset release SHALL register as a fresh press once debounced.
REQ-030 Reset asserted mid-edit SHALL discard pending and clr_pend; no update occurs at the next frame_tick.

Verification (DB_CYCLES=4, REPEAT_DELAY=3, REPEAT_RATE=2)
REQ-031 Press inc for 3 cycles only (glitch), then frame_tick -> register stays 00, changed never pulses.
REQ-032 From 00, hold inc across 8 frame_ticks -> register 01, 01, 01, 02, 02, 03, 03, 04; changed pulses 4 times.
REQ-033 WRAP=1, register FF, one inc press, frame_tick -> 00 with changed; WRAP=0 -> stays FF, no changed.
REQ-034 Three inc presses and one clr within one frame -> register = RESET_VALUE at the next frame_tick.
REQ-035 inc and dec held together -> no change over 5 frames; release dec while inc is held -> no step until inc is re-pressed.
REQ-036 With pending=+2, assert rst_n low for 1 cycle, then frame_tick -> register 00, no changed pulse.

Source files
------------

// File: rtl/btn_reg_edit.sv
// Button-driven 8-bit register editor: debounced inc/dec/clr buttons with auto-repeat,
// accumulated into a pending delta that is applied to the register once per video frame.
module btn_reg_edit #(
    parameter int         DB_CYCLES    = 250000,
    parameter int         REPEAT_DELAY = 30,
    parameter int         REPEAT_RATE  = 6,
    parameter logic [7:0] RESET_VALUE  = 8'h00,
    parameter bit         WRAP         = 1'b1
) (
    input  logic       px_clk,
    input  logic       rst_n,
    input  logic       endframe,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       btn_clr,
    output logic [7:0] register,
    output logic       changed
);

    localparam int DBW  = $clog2(DB_CYCLES + 1);
    localparam int FMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int FCW  = $clog2(FMAX + 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] HOLD_INC = 3'd1;
    localparam logic [2:0] HOLD_DEC = 3'd2;
    localparam logic [2:0] REP_INC  = 3'd3;
    localparam logic [2:0] REP_DEC  = 3'd4;

    // Button vectors are ordered {clr, dec, inc}.
    logic [2:0]     sync1, sync2, db, db_q, rise;
    logic [DBW-1:0] db_cnt [3];
    logic           ef_s1, ef_s2, ef_q, frame_tick;

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            db_q  <= '0;
            ef_s1 <= 1'b0;
            ef_s2 <= 1'b0;
            ef_q  <= 1'b0;
            for (int unsigned i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= {btn_clr, btn_dec, btn_inc};
            sync2 <= sync1;
            db_q  <= db;
            ef_s1 <= endframe;
            ef_s2 <= ef_s1;
            ef_q  <= ef_s2;
            for (int unsigned i = 0; i < 3; i++) begin
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DBW'(DB_CYCLES - 1)) begin
                    db[i]     <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign rise       = db & ~db_q;
    assign frame_tick = ef_s2 & ~ef_q;

    logic [2:0]     state, state_nx;
    logic [FCW-1:0] fcnt, fcnt_nx, flim;
    logic           step_inc, step_dec, held, other;

    always_comb begin
        state_nx = state;
        fcnt_nx  = fcnt;
        step_inc = 1'b0;
        step_dec = 1'b0;
        held     = (state == HOLD_INC || state == REP_INC) ? db[0] : db[1];
        other    = (state == HOLD_INC || state == REP_INC) ? db[1] : db[0];
        flim     = (state == HOLD_INC || state == HOLD_DEC) ? FCW'(REPEAT_DELAY - 1)
                                                            : FCW'(REPEAT_RATE - 1);
        case (state)
            IDLE: begin
                if (rise[0] && !db[1]) begin
                    state_nx = HOLD_INC;
                    step_inc = 1'b1;
                    fcnt_nx  = '0;
                end else if (rise[1] && !db[0]) begin
                    state_nx = HOLD_DEC;
                    step_dec = 1'b1;
                    fcnt_nx  = '0;
                end
            end
            HOLD_INC, HOLD_DEC, REP_INC, REP_DEC: begin
                if (!held || other) begin
                    state_nx = IDLE;
                end else if (frame_tick) begin
                    if (fcnt == flim) begin
                        fcnt_nx = '0;
                        if (state == HOLD_INC) state_nx = REP_INC;
                        if (state == HOLD_DEC) state_nx = REP_DEC;
                        if (state == HOLD_INC || state == REP_INC) step_inc = 1'b1;
                        else                                        step_dec = 1'b1;
                    end else begin
                        fcnt_nx = fcnt + 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    logic signed [4:0] pending, pend_base, pend_nx;
    logic              clr_pend, clr_nx;
    logic signed [9:0] sum;
    logic [7:0]        reg_nx;

    // Pending is cleared by the apply, but a step landing on the apply cycle is kept.
    always_comb begin
        pend_base = frame_tick ? 5'sd0 : pending;
        pend_nx   = pend_base;
        if (step_inc && pend_base != 5'sd15)
            pend_nx = pend_base + 5'sd1;
        else if (step_dec && pend_base != -5'sd16)
            pend_nx = pend_base - 5'sd1;
        clr_nx = (frame_tick ? 1'b0 : clr_pend) | rise[2];

        sum = {2'b00, register} + {{5{pending[4]}}, pending};
        if (clr_pend)
            reg_nx = RESET_VALUE;
        else if (WRAP)
            reg_nx = sum[7:0];
        else if (sum < 10'sd0)
            reg_nx = 8'h00;
        else if (sum > 10'sd255)
            reg_nx = 8'hFF;
        else
            reg_nx = sum[7:0];
    end

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fcnt     <= '0;
            pending  <= '0;
            clr_pend <= 1'b0;
            register <= RESET_VALUE;
            changed  <= 1'b0;
        end else begin
            state    <= state_nx;
            fcnt     <= fcnt_nx;
            pending  <= pend_nx;
            clr_pend <= clr_nx;
            changed  <= 1'b0;
            if (frame_tick) begin
                register <= reg_nx;
                changed  <= (reg_nx != register);
            end
        end
    end

endmodule

// File: tb/tb_btn_reg_edit.sv
// Randomized bench for btn_reg_edit: two instances (wrapping from 00, saturating from FF)
// compared frame by frame against a frame-level model of steps, repeats and clears.
module tb_btn_reg_edit;

    localparam int DB = 4;
    localparam int RD = 3;
    localparam int RR = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       endframe = 1'b0;
    logic       btn_inc = 1'b0, btn_dec = 1'b0, btn_clr = 1'b0;
    logic [7:0] reg0, reg1;
    logic       chg0, chg1;

    always #5 clk = ~clk;

    btn_reg_edit #(.DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR),
                   .RESET_VALUE(8'h00), .WRAP(1'b1)) dut0 (
        .px_clk(clk), .rst_n(rst_n), .endframe(endframe), .btn_inc(btn_inc),
        .btn_dec(btn_dec), .btn_clr(btn_clr), .register(reg0), .changed(chg0));

    btn_reg_edit #(.DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR),
                   .RESET_VALUE(8'hFF), .WRAP(1'b0)) dut1 (
        .px_clk(clk), .rst_n(rst_n), .endframe(endframe), .btn_inc(btn_inc),
        .btn_dec(btn_dec), .btn_clr(btn_clr), .register(reg1), .changed(chg1));

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Register-change and changed-pulse counters seen from the outside.
    int         n_rc0 = 0, n_rc1 = 0, n_ch0 = 0, n_ch1 = 0;
    logic [7:0] prev0, prev1;
    always @(negedge clk) begin
        if (reg0 !== prev0) n_rc0++;
        if (reg1 !== prev1) n_rc1++;
        prev0 = reg0;
        prev1 = reg1;
        if (chg0) n_ch0++;
        if (chg1) n_ch1++;
    end
    int snap_rc0, snap_rc1;

    // Reference model: state 0 = no steps, 1 = waiting for first repeat, 2 = repeating.
    int m_reg0, m_reg1, m_pend, m_state, m_dir, m_cnt;
    bit m_clr;
    bit h_inc = 1'b0, h_dec = 1'b0;

    function automatic void m_step(input int d);
        m_pend = m_pend + d;
        if (m_pend > 15)  m_pend = 15;
        if (m_pend < -16) m_pend = -16;
    endfunction

    function automatic int apply_wrap(input int r, input int p);
        return ((r + p) % 256 + 256) % 256;
    endfunction

    function automatic int apply_sat(input int r, input int p);
        int s = r + p;
        if (s < 0)   s = 0;
        if (s > 255) s = 255;
        return s;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0:       btn_inc = v;
            1:       btn_dec = v;
            default: btn_clr = v;
        endcase
    endtask

    task automatic tap(input int b);
        set_btn(b, 1'b1);
        idle(12);
        set_btn(b, 1'b0);
        idle(12);
        if (b == 2) m_clr = 1'b1;
        else        m_step(b == 0 ? 1 : -1);
    endtask

    task automatic glitch();
        btn_inc = 1'b1;
        idle(DB - 1);
        btn_inc = 1'b0;
        idle(12);
    endtask

    task automatic hold_start(input int b);
        set_btn(b, 1'b1);
        idle(12);
        m_step(b == 0 ? 1 : -1);
        m_state = 1;
        m_dir = (b == 0) ? 1 : -1;
        m_cnt = 0;
        if (b == 0) h_inc = 1'b1; else h_dec = 1'b1;
    endtask

    task automatic press_second();
        if (h_inc) begin btn_dec = 1'b1; h_dec = 1'b1; end
        else       begin btn_inc = 1'b1; h_inc = 1'b1; end
        idle(12);
        m_state = 0;
    endtask

    task automatic release_one(input int b);
        set_btn(b, 1'b0);
        if (b == 0) h_inc = 1'b0; else h_dec = 1'b0;
        idle(12);
    endtask

    task automatic release_all();
        btn_inc = 1'b0;
        btn_dec = 1'b0;
        h_inc = 1'b0;
        h_dec = 1'b0;
        idle(12);
        m_state = 0;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        #1;
        check("rst_reg0", reg0, 8'h00);
        check("rst_reg1", reg1, 8'hFF);
        check("rst_chg", {chg1, chg0}, 2'b00);
        idle(n);
        rst_n = 1'b1;
        idle(2);
        m_reg0 = 8'h00; m_reg1 = 8'hFF;
        m_pend = 0; m_clr = 1'b0; m_state = 0; m_cnt = 0;
        snap_rc0 = n_rc0; snap_rc1 = n_rc1;
    endtask

    task automatic do_frame(input string tag);
        int old0, old1, ch0_before, ch1_before;
        check({tag, "_quiet0"}, n_rc0 - snap_rc0, 0);
        check({tag, "_quiet1"}, n_rc1 - snap_rc1, 0);
        old0 = m_reg0;
        old1 = m_reg1;
        if (m_clr) begin
            m_reg0 = 8'h00;
            m_reg1 = 8'hFF;
        end else begin
            m_reg0 = apply_wrap(old0, m_pend);
            m_reg1 = apply_sat(old1, m_pend);
        end
        m_pend = 0;
        m_clr = 1'b0;
        if (m_state == 1) begin
            m_cnt++;
            if (m_cnt == RD) begin m_state = 2; m_cnt = 0; m_step(m_dir); end
        end else if (m_state == 2) begin
            m_cnt++;
            if (m_cnt == RR) begin m_cnt = 0; m_step(m_dir); end
        end
        ch0_before = n_ch0;
        ch1_before = n_ch1;
        endframe = 1'b1;
        idle(3);
        endframe = 1'b0;
        idle(8);
        check({tag, "_reg0"}, reg0, m_reg0);
        check({tag, "_reg1"}, reg1, m_reg1);
        check({tag, "_chg0"}, n_ch0 - ch0_before, (m_reg0 != old0) ? 1 : 0);
        check({tag, "_chg1"}, n_ch1 - ch1_before, (m_reg1 != old1) ? 1 : 0);
        snap_rc0 = n_rc0;
        snap_rc1 = n_rc1;
    endtask

    logic [7:0] exp32 [8];

    initial begin
        exp32 = '{8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 8'h03, 8'h03, 8'h04};
        idle(1);
        do_reset(3);

        glitch();
        do_frame("glitch");

        hold_start(0);
        for (int k = 0; k < 8; k++) begin
            do_frame("hold");
            check("hold_seq", reg0, exp32[k]);
        end
        release_all();
        do_frame("release");

        tap(2);
        do_frame("clr");
        tap(0);
        do_frame("sat_hi");
        check("sat_hi_const", reg1, 8'hFF);
        tap(1);
        tap(1);
        do_frame("dec2");
        tap(0);
        do_frame("wrap");
        check("wrap_const", reg0, 8'h00);

        for (int k = 0; k < 3; k++) tap(0);
        tap(2);
        do_frame("incs_clr");

        hold_start(0);
        press_second();
        for (int k = 0; k < 5; k++) do_frame("both");
        release_one(1);
        for (int k = 0; k < 3; k++) do_frame("inc_left");
        release_all();

        tap(0);
        tap(0);
        do_reset(1);
        do_frame("rst_mid");
        check("rst_mid_const", reg0, 8'h00);

        btn_inc = 1'b1;
        idle(2);
        do_reset(1);
        idle(12);
        m_step(1);
        m_state = 1; m_dir = 1; m_cnt = 0; h_inc = 1'b1;
        release_all();
        do_frame("held_rst");

        for (int f = 0; f < 40; f++) begin
            int r;
            r = $urandom_range(0, 8);
            case (r)
                1, 2: if (!h_inc && !h_dec) repeat ($urandom_range(1, 20)) tap(r - 1);
                3:    tap(2);
                4:    if (!h_inc && !h_dec) hold_start($urandom_range(0, 1));
                5:    release_all();
                6:    if (!h_inc && !h_dec) glitch();
                7:    if (h_inc != h_dec) press_second();
                8:    if (h_inc && h_dec) release_one($urandom_range(0, 1));
                default: idle(5);
            endcase
            do_frame("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
